mem_bus_responder: RTL
======================

Name: mem_bus_responder

Overview:
- Word-wide memory responder: the slave end of the cache hierarchy's external bus (mem_r/mem_w/mem_addr/mem_wdata -> mem_rdata/mem_ready).
- Backs the bus with an internal word RAM and a programmable access latency.
- Used as the main-memory model/controller behind the cache's memory buffer in simulation and on FPGA.

Parameters:
- ADDR_W, 12, word-address width; RAM depth = 2**ADDR_W words.
- LATENCY, 4, cycles from request acceptance to mem_ready pulse; legal range 1..255.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to the RAM size.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- mem_r  input  1  read request, held by the initiator until mem_ready.
- mem_w  input  1  write request, held by the initiator until mem_ready.
- mem_addr  input  32  byte address; bits [1:0] ignored.
- mem_wdata  input  32  write data.
- mem_rdata  output  32  read data, valid in the mem_ready cycle and held until the next read completes.
- mem_ready  output  1  single-cycle completion pulse.
- mem_err  output  1  single-cycle pulse with mem_ready on an out-of-range access.
- rd_count  output  32  completed-read counter (see Optional Feature).
- wr_count  output  32  completed-write counter (see Optional Feature).

Behaviour:
- Reset values: mem_rdata=0, mem_ready=0, mem_err=0, rd_count=0, wr_count=0, state=IDLE, latency counter=0. RAM contents are not cleared.
- Reset is synchronous and wins over everything. Reset during BUSY aborts the access: no RAM write commits and no ready pulse is issued.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If mem_r|mem_w is high at a clock edge, latch op, word index and wdata; load cnt=LATENCY-1.
  - If LATENCY==1, go straight to DONE; otherwise go to BUSY.
- BUSY:
  - Decrement cnt each cycle. Go to DONE when cnt reaches 1 in the current cycle.
  - Input changes during BUSY are ignored; the latched values are used.
- DONE (one cycle):
  - mem_ready=1.
  - Read: mem_rdata=RAM[idx].
  - Write: RAM[idx]=latched wdata, committed at the DONE edge.
  - Next state is IDLE.
- Latency: request first sampled high at edge T -> mem_ready high during cycle T+LATENCY.
- Back-to-back:
  - The initiator drops or changes its request in the cycle after mem_ready.
  - In that cycle the FSM is IDLE and samples again. A still-asserted request starts a new access.
  - Minimum spacing between two ready pulses is LATENCY+1 cycles.
- Simultaneous mem_r and mem_w: treated as a write; mem_rdata is unchanged.
- Range check:
  - Hit when (mem_addr - BASE_ADDR) < 4*2**ADDR_W, using 32-bit unsigned subtraction so wrap-around below BASE_ADDR counts as a miss.
  - Miss on a read: mem_rdata=0 and mem_err=1 with mem_ready.
  - Miss on a write: RAM unchanged and mem_err=1 with mem_ready.
- Word index = (mem_addr - BASE_ADDR)[ADDR_W+1:2].
- mem_ready and mem_err are registered outputs; no combinational path from inputs to outputs.

Optional Feature:
- Macro: MEM_BUS_STATS_EN.
- Defined:
  - rd_count increments by 1 in each read DONE cycle; wr_count increments in each write DONE cycle. Out-of-range accesses are included.
  - Both wrap modulo 2**32 and clear on rst.
- Undefined: rd_count and wr_count are constant 0 and no counter flops are synthesized.

Test Plan:
- LATENCY=4, rst, then write 0x0000_0010 <= 0xDEADBEEF held until ready -> mem_ready high exactly 4 cycles after acceptance, mem_err=0. Then read 0x10 -> mem_rdata=0xDEADBEEF in the ready cycle and held afterwards.
- Four back-to-back writes 0x20/0x24/0x28/0x2C (data 1..4) with requests held through each ready, then four reads -> returns 1,2,3,4; ready pulses spaced 5 cycles apart.
- mem_r and mem_w both high, addr 0x30, wdata 0x55 -> treated as write; a subsequent read of 0x30 returns 0x55; mem_rdata unchanged by the combined access.
- ADDR_W=12, BASE_ADDR=0: read 0x0000_4000 -> mem_rdata=0, mem_err=1 with ready. Write to 0x4000 leaves RAM[0] unchanged.
- Write 0x40 <= 0xA5A5A5A5 with rst pulsed in the 2nd BUSY cycle -> no mem_ready; a later read of 0x40 returns the prior value (0 after a preloaded write of 0).
- With MEM_BUS_STATS_EN: 3 reads + 2 writes -> rd_count=3, wr_count=2; rst -> both 0. Without the macro: both stay 0 throughout.

Source files
------------

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: word-wide bus slave backed by an internal RAM with
// a programmable access latency. Optional stats counters: MEM_BUS_STATS_EN.
//
// Ports:
//   clk, rst (sync, active-high)
//   mem_r, mem_w, mem_addr, mem_wdata  : request, held until mem_ready
//   mem_rdata, mem_ready, mem_err      : registered response
//   rd_count, wr_count                 : completed-access counters
//     (constant 0 unless MEM_BUS_STATS_EN is defined)
module mem_bus_responder #(
  parameter int          ADDR_W    = 12,
  parameter int          LATENCY   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_err,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam int          DEPTH = 2 ** ADDR_W;
  // 33 bits so ADDR_W=30 still yields a full 4 GiB window.
  localparam logic [32:0] SPAN  = 33'd4 << ADDR_W;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic                hit_q, hit_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;

  logic [31:0]         ram [DEPTH];

  logic                req;
  logic                accept;
  logic [31:0]         off;
  logic                hit_in;
  logic [ADDR_W-1:0]   idx_in;
  logic                wr_sel;
  logic                hit_sel;
  logic [ADDR_W-1:0]   idx_sel;
  logic                enter_done;

  assign req    = mem_r | mem_w;
  assign accept = (state_q == IDLE) & req;
  // Unsigned wrap makes addresses below BASE_ADDR fall out of range.
  assign off    = mem_addr - BASE_ADDR;
  assign hit_in = ({1'b0, off} < SPAN);
  assign idx_in = off[ADDR_W+1:2];

  // With LATENCY==1 the DONE entry happens on the accept edge, so the
  // response path must see the live request rather than the latches.
  assign wr_sel  = accept ? mem_w  : wr_q;
  assign hit_sel = accept ? hit_in : hit_q;
  assign idx_sel = accept ? idx_in : idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = 8'(LATENCY - 1);
          state_d = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_done = (state_d == DONE);

  always_comb begin
    wr_d    = wr_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = enter_done;
    err_d   = enter_done & ~hit_sel;
    if (accept) begin
      wr_d    = mem_w;
      hit_d   = hit_in;
      idx_d   = idx_in;
      wdata_d = mem_wdata;
    end
    if (enter_done && !wr_sel) begin
      rdata_d = hit_sel ? ram[idx_sel] : 32'h0;
    end
  end

  // Write commits on the edge that leaves DONE; reset suppresses it.
  always_ff @(posedge clk) begin
    if (!rst && state_q == DONE && wr_q && hit_q) begin
      ram[idx_q] <= wdata_q;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign mem_err   = err_q;

`ifdef MEM_BUS_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (enter_done) begin
      if (wr_sel) wr_cnt_q <= wr_cnt_q + 32'd1;
      else        rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = 32'h0;
  assign wr_count = 32'h0;
`endif

endmodule
